// File: rtl/comparator_8bit.sv
// Registered 8-bit unsigned magnitude comparator built from two cascaded 4-bit stages.
// Optional macro COMPARATOR_8BIT_CASCADE_ONEHOT_EN forces one-hot tie outputs (priority e, l, g).
module comparator_8bit (
    input  logic clk,
    input  logic rst,
    input  logic a0,
    input  logic a1,
    input  logic a2,
    input  logic a3,
    input  logic a4,
    input  logic a5,
    input  logic a6,
    input  logic a7,
    input  logic b0,
    input  logic b1,
    input  logic b2,
    input  logic b3,
    input  logic b4,
    input  logic b5,
    input  logic b6,
    input  logic b7,
    input  logic l,
    input  logic e,
    input  logic g,
    output logic lt,
    output logic eq,
    output logic gt
);

    localparam int unsigned NIB_W = 4;
    localparam int unsigned DAT_W = 2 * NIB_W;
    localparam int unsigned RES_W = 3;

    // Result vectors are ordered {lt, eq, gt}.
    localparam logic [RES_W-1:0] RES_LT = 3'b100;
    localparam logic [RES_W-1:0] RES_EQ = 3'b010;
    localparam logic [RES_W-1:0] RES_GT = 3'b001;

    logic [DAT_W-1:0] a;
    logic [DAT_W-1:0] b;
    logic [RES_W-1:0] tie;
    logic [RES_W-1:0] lo_res;
    logic [RES_W-1:0] hi_res;

    assign a = {a7, a6, a5, a4, a3, a2, a1, a0};
    assign b = {b7, b6, b5, b4, b3, b2, b1, b0};

    function automatic logic [RES_W-1:0] nib_cmp(
        input logic [NIB_W-1:0] x,
        input logic [NIB_W-1:0] y,
        input logic [RES_W-1:0] casc
    );
        if (x > y) begin
            return RES_GT;
        end else if (x < y) begin
            return RES_LT;
        end else begin
            return casc;
        end
    endfunction

    // Cascade value used when both operands are fully equal.
    always_comb begin
        tie = {l, e, g};
`ifdef COMPARATOR_8BIT_CASCADE_ONEHOT_EN
        if (e) begin
            tie = RES_EQ;
        end else if (l) begin
            tie = RES_LT;
        end else if (g) begin
            tie = RES_GT;
        end else begin
            tie = RES_EQ;
        end
`endif
    end

    // Low nibble feeds the high nibble, which has the final say.
    always_comb begin
        lo_res = nib_cmp(a[NIB_W-1:0], b[NIB_W-1:0], tie);
        hi_res = nib_cmp(a[DAT_W-1:NIB_W], b[DAT_W-1:NIB_W], lo_res);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {lt, eq, gt} <= '0;
        end else begin
            {lt, eq, gt} <= hi_res;
        end
    end

endmodule

// File: tb/tb_comparator_8bit.sv
// Directed self-checking bench for comparator_8bit; results compared as {lt, eq, gt}.
module tb_comparator_8bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       l   = 1'b0;
    logic       e   = 1'b0;
    logic       g   = 1'b0;
    logic       lt;
    logic       eq;
    logic       gt;

    int checks   = 0;
    int failures = 0;

    comparator_8bit dut (
        .clk(clk), .rst(rst),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
        .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
        .b4(b[4]), .b5(b[5]), .b6(b[6]), .b7(b[7]),
        .l(l), .e(e), .g(g),
        .lt(lt), .eq(eq), .gt(gt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got {lt,eq,gt}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic [2:0] leg);
        a = av;
        b = bv;
        {l, e, g} = leg;
    endtask

    // Apply one vector, clock it in, then sample just after the edge.
    task automatic run_vec(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [2:0] leg, input logic [2:0] exp);
        drive(av, bv, leg);
        @(posedge clk);
        #1;
        check(tag, {lt, eq, gt}, exp);
    endtask

    initial begin
        // Reset with a strong "greater" operand pair present.
        rst = 1'b1;
        drive(8'hFF, 8'h00, 3'b000);
        @(posedge clk);
        #1;
        check("reset", {lt, eq, gt}, 3'b000);

        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_gt", {lt, eq, gt}, 3'b001);

        // Inputs changing mid-cycle must not disturb the registered outputs.
        drive(8'h00, 8'hFF, 3'b010);
        #2;
        check("hold_mid_cycle", {lt, eq, gt}, 3'b001);
        @(posedge clk);
        #1;
        check("after_toggle_lt", {lt, eq, gt}, 3'b100);

        run_vec("tie01_e", 8'h01, 8'h01, 3'b010, 3'b010);
        run_vec("tie01_l", 8'h01, 8'h01, 3'b100, 3'b100);
        run_vec("tie01_g", 8'h01, 8'h01, 3'b001, 3'b001);

        run_vec("gt02_e", 8'h02, 8'h01, 3'b010, 3'b001);
        run_vec("gt02_l", 8'h02, 8'h01, 3'b100, 3'b001);
        run_vec("gt02_g", 8'h02, 8'h01, 3'b001, 3'b001);

        run_vec("lt20_e", 8'h20, 8'h40, 3'b010, 3'b100);
        run_vec("lt20_l", 8'h20, 8'h40, 3'b100, 3'b100);
        run_vec("lt20_g", 8'h20, 8'h40, 3'b001, 3'b100);

        run_vec("tie00", 8'h00, 8'h00, 3'b010, 3'b010);
        run_vec("tieFF", 8'hFF, 8'hFF, 3'b100, 3'b100);
        run_vec("ff_vs_00", 8'hFF, 8'h00, 3'b100, 3'b001);
        run_vec("00_vs_ff", 8'h00, 8'hFF, 3'b001, 3'b100);
        run_vec("bit0_gt", 8'h01, 8'h00, 3'b100, 3'b001);
        run_vec("bit0_lt", 8'h00, 8'h01, 3'b001, 3'b100);
        run_vec("bit0_hi_gt", 8'hA5, 8'hA4, 3'b100, 3'b001);
        run_vec("hi_nib_wins", 8'h80, 8'h7F, 3'b100, 3'b001);
        run_vec("lo_nib_decides", 8'h17, 8'h18, 3'b001, 3'b100);

`ifdef COMPARATOR_8BIT_CASCADE_ONEHOT_EN
        run_vec("tie55_111", 8'h55, 8'h55, 3'b111, 3'b010);
        run_vec("tie55_000", 8'h55, 8'h55, 3'b000, 3'b010);
        run_vec("tie55_101", 8'h55, 8'h55, 3'b101, 3'b100);
`else
        run_vec("tie55_111", 8'h55, 8'h55, 3'b111, 3'b111);
        run_vec("tie55_000", 8'h55, 8'h55, 3'b000, 3'b000);
        run_vec("tie55_101", 8'h55, 8'h55, 3'b101, 3'b101);
`endif

        // Mid-stream reset discards the pending comparison.
        rst = 1'b1;
        run_vec("midstream_reset", 8'hFF, 8'h00, 3'b000, 3'b000);
        rst = 1'b0;
        run_vec("after_midstream", 8'h00, 8'hFF, 3'b000, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparator_8bit.md
COMPARATOR_8BIT -- requirements
Module: comparator_8bit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all other ports are listed below, clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a0..a7  input  1 each  operand A as scalar bits; a0 = LSB, a7 = MSB; unsigned.
REQ-005 b0..b7  input  1 each  operand B as scalar bits; b0 = LSB, b7 = MSB; unsigned.
REQ-006 l  input  1  cascade "less" from a lower-order stage.
REQ-007 e  input  1  cascade "equal" from a lower-order stage.
REQ-008 g  input  1  cascade "greater" from a lower-order stage.
REQ-009 lt  output  1  registered A<B result.
REQ-010 eq  output  1  registered A==B result.
REQ-011 gt  output  1  registered A>B result.

Function
REQ-012 Comparison SHALL be unsigned magnitude on A = {a7..a0} and B = {b7..b0}.
REQ-013 A>B SHALL produce next state gt=1, lt=0, eq=0, regardless of l/e/g.
REQ-014 A<B SHALL produce next state lt=1, gt=0, eq=0, regardless of l/e/g.
REQ-015 A==B SHALL pass the cascade inputs through: next lt=l, eq=e, gt=g (subject to REQ-022).
REQ-016 Comparison logic SHALL be two cascaded 4-bit magnitude stages: the high nibble decides; on a high-nibble tie, the low-nibble result decides; on a full tie, the cascade inputs decide.
REQ-017 Outputs SHALL be registered: values sampled at rising edge N appear on lt/eq/gt after edge N; latency is exactly 1 cycle, throughput is 1 comparison per cycle.
REQ-018 Between edges, outputs SHALL hold steady regardless of input changes.
REQ-019 Boundary cases: A=B=0x00 and A=B=0xFF follow the tie rule; A=0xFF, B=0x00 gives gt; A=0x00, B=0xFF gives lt; a difference only in bit 0 SHALL be resolved correctly.

Reset
REQ-020 When rst=1 at a rising edge, lt, eq and gt SHALL all be 0 after that edge, overriding any comparison.
REQ-021 The first edge with rst=0 SHALL load a normal comparison result; asserting reset mid-stream discards the pending result.

Configuration
REQ-022 Macro COMPARATOR_8BIT_CASCADE_ONEHOT_EN controls the tie case. When defined and A==B, outputs SHALL be forced one-hot with priority e, then l, then g; if none of l/e/g is high, eq=1. When undefined, l/e/g SHALL pass through raw, including illegal combinations.

Verification
REQ-023 A=0x01, B=0x01 with (l,e,g) applied in turn as (0,1,0), (1,0,0), (0,0,1) -> after one edge each, (lt,eq,gt) = (0,1,0), (1,0,0), (0,0,1).
REQ-024 A=0x02, B=0x01 with each of the three cascade patterns -> gt=1, lt=0, eq=0 every time.
REQ-025 A=0x20, B=0x40 with each of the three cascade patterns -> lt=1, eq=0, gt=0 every time.
REQ-026 With A=0xFF, B=0x00 held, assert rst for one edge -> outputs 0,0,0; release rst -> gt=1 after the next edge; toggle inputs mid-cycle -> outputs unchanged until the next edge.
REQ-027 A=B=0x55 with (l,e,g)=(1,1,1) -> with the macro, eq=1 only; without it, lt=eq=gt=1. With (l,e,g)=(0,0,0) -> with the macro, eq=1; without it, all outputs 0.
